inst_dispatch: RTL and testbench
================================

Name: inst_dispatch

Overview:
- Host-side transmitter for the MPU instruction-buffer write interface: drives `in`, `IB_wen` and `start` while obeying `buf_full`.
- Holds a small host-loaded program RAM. On `go`, it streams `prog_len` 13-bit instruction words into the instruction buffer in address order.
- After the last word is accepted, it pulses `start` to launch fetch, then signals `done`.
- Sits between the host/test controller and the MPU top level.

Parameters:
- IW, 13, instruction word width; matches the MPU `in` port.
- DEPTH, 32, program RAM depth in words.
- AW, 5, program RAM address width; DEPTH = 2**AW.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-low reset (sampled on clk rising edge; 0 = reset).
- prog_we  input  1  host program-RAM write strobe.
- prog_addr  input  AW  host program-RAM write address.
- prog_data  input  IW  host program-RAM write data.
- prog_len  input  AW+1  number of words to send, 0..DEPTH; sampled on go.
- go  input  1  one-cycle request to begin dispatch.
- buf_full  input  1  instruction buffer full, from the MPU.
- in  output  IW  instruction word to the instruction buffer.
- IB_wen  output  1  instruction-buffer write enable.
- start  output  1  one-cycle pulse to the MPU fetch stage.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle completion pulse.
- sent_cnt  output  AW+1  number of words accepted in the current or last run.

Behaviour:
- Reset (rst=0 at an edge), regardless of state:
  - state=IDLE, ptr=0, len_q=0, sent_cnt=0.
  - in=0, IB_wen=0, start=0, busy=0, done=0.
  - Program RAM contents are not cleared.
- Program RAM:
  - Write `prog_data` to `prog_addr` on an edge with prog_we=1, only when state==IDLE.
  - In any other state prog_we is ignored.
  - A write and go in the same IDLE cycle: the write completes first, and the dispatch sees the new word.
- States: IDLE, SEND, LAUNCH, FIN.
- IDLE:
  - go=1 latches len_q = min(prog_len, DEPTH), ptr=0, sent_cnt=0.
  - If len_q==0 the next state is LAUNCH; otherwise SEND.
  - go=0 stays in IDLE.
- SEND:
  - IB_wen = !buf_full (combinational, so no write is issued into a full buffer).
  - in = mem[ptr] while state is SEND, else 0.
  - On an edge with IB_wen=1: ptr++ and sent_cnt++.
  - If that was word len_q-1, the next state is LAUNCH.
  - buf_full=1 stalls: IB_wen=0, ptr holds, `in` holds the same word.
  - go is ignored while not in IDLE.
- LAUNCH: start=1 for exactly one cycle, then FIN.
- FIN: done=1 for exactly one cycle, then IDLE.
- Outputs:
  - start and done are decoded from state and mutually exclusive.
  - busy = (state!=IDLE).
  - sent_cnt holds its value in IDLE until the next go.
- Timing:
  - Latency from go to the first IB_wen is 1 cycle (the SEND state).
  - A unstalled run of N words takes go + N SEND cycles + 1 LAUNCH + 1 FIN.
- Pointer wrap: len_q ≤ DEPTH guarantees ptr never wraps within a run. ptr is AW+1 bits wide internally; the RAM is indexed by ptr[AW-1:0].
- Reset mid-run: the run is abandoned immediately. No further IB_wen, start or done is issued, and already-written words remain in the instruction buffer.

Test Plan:
1. Load mem[0..3]=13'h0011,13'h0022,13'h0033,13'h0044, prog_len=4, go, buf_full=0 -> IB_wen high for 4 consecutive cycles with in=0011,0022,0033,0044; then start pulse 1 cycle; then done 1 cycle; sent_cnt=4.
2. Same program with buf_full=1 for 3 cycles while word 2 is presented -> IB_wen=0 during the stall, in held at 0033; total IB_wen count is 4 with no duplicate and no skipped word.
3. prog_len=0, go -> no IB_wen; start next cycle; done the cycle after; sent_cnt=0.
4. prog_len=40 with DEPTH=32 -> exactly 32 writes (mem[0]..mem[31]), no wrap; sent_cnt=32.
5. rst=0 during SEND after 2 words -> next cycle all outputs 0 and state IDLE; a new go with prog_len=1 sends mem[0] only.
6. prog_we during SEND to address 3 -> ignored; word 3 sent is the pre-run value. prog_we and go in the same IDLE cycle on addr 0 -> the new value is sent first.

Source files
------------

// File: rtl/inst_dispatch_if.sv
// inst_dispatch_if: instruction-buffer write channel between the dispatcher and the MPU
interface inst_dispatch_if #(parameter int IW = 13);
  logic [IW-1:0] in;
  logic IB_wen, start, buf_full;
  modport master (output in, IB_wen, start, input buf_full);
  modport slave (input in, IB_wen, start, output buf_full);
endinterface

// File: rtl/inst_dispatch.sv
// inst_dispatch: streams a host-loaded program into the MPU instruction buffer, then pulses start and done
module inst_dispatch #(
  parameter int IW = 13,
  parameter int DEPTH = 32,
  parameter int AW = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic [AW:0] prog_len,
  input  logic go,
  inst_dispatch_if.master ib,
  output logic busy,
  output logic done,
  output logic [AW:0] sent_cnt
);
  typedef enum logic [1:0] {IDLE, SEND, LAUNCH, FIN} state_t;
  state_t state_q, state_d;
  logic [AW:0] ptr_q, ptr_d, len_q, len_d, len_go;
  logic [IW-1:0] mem [DEPTH];
  logic wen;
  always_ff @(posedge clk)
    if (prog_we && state_q == IDLE) mem[prog_addr] <= prog_data;
  always_ff @(posedge clk)
    if (!rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      len_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      len_q <= len_d;
    end
  // ptr doubles as the accepted-word count, so sent_cnt holds in IDLE until the next go
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    len_d = len_q;
    len_go = prog_len > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : prog_len;
    wen = state_q == SEND && !ib.buf_full;
    case (state_q)
      IDLE: if (go) begin
        len_d = len_go;
        ptr_d = '0;
        state_d = len_go == '0 ? LAUNCH : SEND;
      end
      SEND: if (wen) begin
        ptr_d = ptr_q + 1'b1;
        state_d = ptr_q + 1'b1 == len_q ? LAUNCH : SEND;
      end
      LAUNCH: state_d = FIN;
      default: state_d = IDLE;
    endcase
  end
  assign ib.IB_wen = wen;
  assign ib.in = state_q == SEND ? mem[ptr_q[AW-1:0]] : '0;
  assign ib.start = state_q == LAUNCH;
  assign done = state_q == FIN;
  assign busy = state_q != IDLE;
  assign sent_cnt = ptr_q;
endmodule

// File: tb/tb_inst_dispatch.sv
// tb_inst_dispatch: random-stall dispatch runs checked against a shadow program and the expected word stream
module tb_inst_dispatch;
  logic clk = 0, rst = 0, prog_we = 0, go = 0;
  logic [4:0] prog_addr = 0;
  logic [12:0] prog_data = 0;
  logic [5:0] prog_len = 0;
  logic busy, done;
  logic [5:0] sent_cnt;
  logic [12:0] mem_m [32];
  int total = 0, bad = 0;
  inst_dispatch_if #(.IW(13)) ib ();
  inst_dispatch dut (.clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_len(prog_len), .go(go), .ib(ib), .busy(busy), .done(done), .sent_cnt(sent_cnt));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask
  task automatic wr(input logic [4:0] a, input logic [12:0] d);
    @(negedge clk);
    prog_we = 1; prog_addr = a; prog_data = d;
    mem_m[a] = d;
    @(negedge clk);
    prog_we = 0;
  endtask
  // sw/sn force sn stalled cycles while word sw is presented; wr_busy pokes addr 3 mid-run; wr_go writes addr 0 with go
  task automatic run(input int len, input int pct, input int sw, input int sn, input bit wr_busy, input bit wr_go,
                     input logic [12:0] wd);
    int n, got;
    bit launched, fin;
    n = len > 32 ? 32 : len;
    got = 0; launched = 0; fin = 0;
    @(negedge clk);
    prog_len = 6'(len);
    go = 1;
    if (wr_go) begin
      prog_we = 1; prog_addr = 0; prog_data = wd;
      mem_m[0] = wd;
    end
    @(negedge clk);
    go = 0; prog_we = 0;
    for (int c = 0; c < 400 && !fin; c++) begin
      bit bf;
      bf = (got == sw && sn > 0) ? 1'b1 : (int'($urandom_range(99)) < pct);
      if (got == sw && sn > 0) sn--;
      buf_full_drive(bf);
      if (wr_busy && got == 1) begin
        prog_we = 1; prog_addr = 3; prog_data = ~mem_m[3];
      end
      #1;
      if (got < n) begin
        chk("wen", ib.IB_wen, !bf);
        chk("word", ib.in, mem_m[got]);
        chk("cnt", sent_cnt, got);
        chk("start_send", ib.start, 0);
        chk("busy", busy, 1);
        if (!bf) got++;
      end else if (!launched) begin
        chk("start", ib.start, 1);
        chk("wen_launch", ib.IB_wen, 0);
        chk("done_launch", done, 0);
        launched = 1;
      end else begin
        chk("done", done, 1);
        chk("start_fin", ib.start, 0);
        chk("cnt_fin", sent_cnt, n);
        fin = 1;
      end
      @(negedge clk);
      prog_we = 0;
    end
    chk("finished", fin, 1);
    buf_full_drive(0);
    #1;
    chk("busy_idle", busy, 0);
    chk("done_idle", done, 0);
    chk("in_idle", ib.in, 0);
    chk("cnt_hold", sent_cnt, n);
  endtask
  task automatic buf_full_drive(input bit b);
    ib.buf_full = b;
  endtask
  initial begin
    ib.buf_full = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wen", ib.IB_wen, 0);
    chk("rst_start", ib.start, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", sent_cnt, 0);
    chk("rst_in", ib.in, 0);
    rst = 1;
    wr(0, 13'h0011); wr(1, 13'h0022); wr(2, 13'h0033); wr(3, 13'h0044);
    for (int i = 4; i < 32; i++) wr(5'(i), 13'($urandom));
    run(4, 0, -1, 0, 0, 0, 0);
    run(4, 0, 2, 3, 0, 0, 0);
    run(0, 0, -1, 0, 0, 0, 0);
    run(40, 0, -1, 0, 0, 0, 0);
    run(6, 0, -1, 0, 1, 0, 0);
    run(3, 0, -1, 0, 0, 1, 13'h1abc);
    // abandon a run after two accepted words
    @(negedge clk);
    prog_len = 8; go = 1;
    @(negedge clk);
    go = 0;
    repeat (2) @(negedge clk);
    rst = 0; ib.buf_full = 1;
    @(negedge clk);
    #1;
    chk("mid_wen", ib.IB_wen, 0);
    chk("mid_start", ib.start, 0);
    chk("mid_done", done, 0);
    chk("mid_busy", busy, 0);
    chk("mid_cnt", sent_cnt, 0);
    chk("mid_in", ib.in, 0);
    rst = 1; ib.buf_full = 0;
    run(1, 0, -1, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      wr(5'($urandom_range(31)), 13'($urandom));
      run(int'($urandom_range(40)), int'($urandom_range(60)), -1, 0, 0, 0, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
